tns_enc_22_seq: RTL and testbench



---
 rtl/tns_enc_22_seq_pkg.sv | 46 ++++
 rtl/tns_weight_sel_22.sv | 39 +++
 rtl/tns_enc_22_seq.sv | 95 +++++++++
 tb/tb_tns_enc_22_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tns_enc_22_seq_pkg.sv
// Shared constants, types and state encoding for the 22-bit TNS encoder.
package tns_enc_22_seq_pkg;

   // Data word width and codeword length.
   localparam int unsigned BLEN08_C     = 20;
   localparam int unsigned TNS_CW22_LEN = 22;
   localparam int unsigned IDX_W        = 5;

   typedef logic [BLEN08_C-1:0]     data_t;
   typedef logic [TNS_CW22_LEN-1:0] code_t;
   typedef logic [IDX_W-1:0]        idx_t;

   // Codeword bit weights, W[0] = TNS01_C up to W[21] = TNS08_C.
   localparam data_t TNS01_C = 20'd1;
   localparam data_t TNS01_B = 20'd2;
   localparam data_t TNS01_A = 20'd4;
   localparam data_t TNS02_C = 20'd7;
   localparam data_t TNS02_B = 20'd13;
   localparam data_t TNS02_A = 20'd24;
   localparam data_t TNS03_C = 20'd44;
   localparam data_t TNS03_B = 20'd81;
   localparam data_t TNS03_A = 20'd149;
   localparam data_t TNS04_C = 20'd274;
   localparam data_t TNS04_B = 20'd504;
   localparam data_t TNS04_A = 20'd927;
   localparam data_t TNS05_C = 20'd1705;
   localparam data_t TNS05_B = 20'd3136;
   localparam data_t TNS05_A = 20'd5768;
   localparam data_t TNS06_C = 20'd10609;
   localparam data_t TNS06_B = 20'd19513;
   localparam data_t TNS06_A = 20'd35890;
   localparam data_t TNS07_C = 20'd66012;
   localparam data_t TNS07_B = 20'd121415;
   localparam data_t TNS07_A = 20'd223317;
   localparam data_t TNS08_C = 20'd410744;

   // Index of the first (most significant) codeword bit resolved.
   localparam idx_t IDX_MSB = idx_t'(TNS_CW22_LEN - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } tns_state_e;

endpackage

// File: rtl/tns_weight_sel_22.sv
// Combinational weight lookup: codeword bit index to its TNS weight.
module tns_weight_sel_22
   import tns_enc_22_seq_pkg::*;
(
   input  logic [IDX_W-1:0]    idx,
   output logic [BLEN08_C-1:0] weight
);

   // Indices beyond bit 21 select a zero weight.
   always_comb begin
      weight = '0;
      case (idx)
         5'd0:    weight = TNS01_C;
         5'd1:    weight = TNS01_B;
         5'd2:    weight = TNS01_A;
         5'd3:    weight = TNS02_C;
         5'd4:    weight = TNS02_B;
         5'd5:    weight = TNS02_A;
         5'd6:    weight = TNS03_C;
         5'd7:    weight = TNS03_B;
         5'd8:    weight = TNS03_A;
         5'd9:    weight = TNS04_C;
         5'd10:   weight = TNS04_B;
         5'd11:   weight = TNS04_A;
         5'd12:   weight = TNS05_C;
         5'd13:   weight = TNS05_B;
         5'd14:   weight = TNS05_A;
         5'd15:   weight = TNS06_C;
         5'd16:   weight = TNS06_B;
         5'd17:   weight = TNS06_A;
         5'd18:   weight = TNS07_C;
         5'd19:   weight = TNS07_B;
         5'd20:   weight = TNS07_A;
         5'd21:   weight = TNS08_C;
         default: weight = '0;
      endcase
   end

endmodule

// File: rtl/tns_enc_22_seq.sv
// Sequential greedy binary-to-TNS encoder, one codeword bit per clock, MSB first.
module tns_enc_22_seq
   import tns_enc_22_seq_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BLEN08_C-1:0]     datain,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [TNS_CW22_LEN-1:0] codeout,
   output logic                    out_err
);

   tns_state_e state_q, state_d;
   data_t      rem_q, rem_d;
   code_t      code_q, code_d;
   idx_t       idx_q, idx_d;
   logic       err_q, err_d;

   data_t      weight;
   logic       take;

   tns_weight_sel_22 u_weight_sel (
      .idx    (idx_q),
      .weight (weight)
   );

   // Unsigned compare; subtraction is only applied when it cannot wrap.
   assign take = (rem_q >= weight);

   // Next-state logic for the handshake FSM and the greedy datapath.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      code_d  = code_q;
      idx_d   = idx_q;
      err_d   = err_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               rem_d   = datain;
               code_d  = '0;
               idx_d   = IDX_MSB;
               err_d   = 1'b0;
               state_d = StRun;
            end
         end
         StRun: begin
            code_d[idx_q] = take;
            if (take) begin
               rem_d = rem_q - weight;
            end
            if (idx_q == '0) begin
               // Anything left after bit 0 cannot be represented.
               err_d   = (rem_d != '0);
               state_d = StDone;
            end else begin
               idx_d = idx_q - idx_t'(1);
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         rem_q   <= '0;
         code_q  <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         code_q  <= code_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   // Handshake flags decode straight from the state register.
   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign codeout   = code_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_tns_enc_22_seq.sv
// Directed and round-trip checks for the 22-bit TNS sequential encoder.
module tb_tns_enc_22_seq;
   import tns_enc_22_seq_pkg::*;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [BLEN08_C-1:0] datain;
   logic                out_valid;
   logic                out_ready;
   logic [21:0]         codeout;
   logic                out_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] w [22];

   typedef struct {
      logic [31:0] data;
      logic [21:0] code;
      logic        err;
   } vec_t;

   vec_t vecs [10];

   always #5 clk = ~clk;

   tns_enc_22_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .datain    (datain),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .codeout   (codeout),
      .out_err   (out_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one word while the encoder is idle; returns just after the accept edge.
   task automatic send(input logic [31:0] d);
      check("accept_ready", {31'd0, in_ready}, 32'd1);
      datain   = d[BLEN08_C-1:0];
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   // Count edges after the accept edge until out_valid, bounded.
   task automatic wait_valid(output int cycles);
      cycles = 0;
      while (!out_valid && cycles < 40) begin
         step();
         cycles++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("post_hs_valid", {31'd0, out_valid}, 32'd0);
      check("post_hs_ready", {31'd0, in_ready}, 32'd1);
   endtask

   function automatic logic [31:0] decode(input logic [21:0] c);
      logic [31:0] s = 0;
      for (int i = 0; i < 22; i++) begin
         if (c[i]) s += w[i];
      end
      return s;
   endfunction

   task automatic run_word(input string name, input logic [31:0] d,
                           input logic [21:0] exp_code, input logic exp_err);
      int cyc;
      send(d);
      wait_valid(cyc);
      check({name, "_latency"}, cyc, 32'd22);
      check({name, "_code"}, {10'd0, codeout}, {10'd0, exp_code});
      check({name, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
      check({name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      handshake();
   endtask

   initial begin
      int          cyc;
      logic        seen;
      logic [31:0] d;
      logic [21:0] hold_code;

      w[0] = 1;
      w[1] = 2;
      w[2] = 4;
      for (int i = 3; i < 22; i++) w[i] = w[i-1] + w[i-2] + w[i-3];

      vecs[0] = '{data: 32'd0,       code: 22'h000000, err: 1'b0};
      vecs[1] = '{data: 32'd410744,  code: 22'h200000, err: 1'b0};
      vecs[2] = '{data: 32'd900139,  code: 22'h3FFFFF, err: 1'b0};
      vecs[3] = '{data: 32'd900140,  code: 22'h3FFFFF, err: 1'b1};
      vecs[4] = '{data: 32'd1048575, code: 22'h3FFFFF, err: 1'b1};
      vecs[5] = '{data: 32'd1,       code: 22'h000001, err: 1'b0};
      vecs[6] = '{data: 32'd3,       code: 22'h000003, err: 1'b0};
      vecs[7] = '{data: 32'd7,       code: 22'h000008, err: 1'b0};
      vecs[8] = '{data: 32'd11,      code: 22'h00000C, err: 1'b0};
      vecs[9] = '{data: 32'd13,      code: 22'h000010, err: 1'b0};

      // Reset held with in_valid high: nothing may be accepted.
      rst       = 1'b1;
      in_valid  = 1'b1;
      datain    = 20'h12345;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_out_valid", {31'd0, out_valid}, 32'd0);
         check("rst_codeout", {10'd0, codeout}, 32'd0);
         check("rst_out_err", {31'd0, out_err}, 32'd0);
         check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      step();
      check("idle_after_rst", {31'd0, in_ready}, 32'd1);

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         run_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].code, vecs[i].err);
      end

      // Backpressure with a second word held on the input.
      send(32'd900139);
      wait_valid(cyc);
      check("bp_latency", cyc, 32'd22);
      hold_code = codeout;
      check("bp_code", {10'd0, hold_code}, 32'h3FFFFF);
      in_valid = 1'b1;
      datain   = 20'd7;
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_stable", {10'd0, codeout}, {10'd0, hold_code});
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_hs_valid", {31'd0, out_valid}, 32'd0);
      check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check("bp_accepted", {31'd0, in_ready}, 32'd0);
      wait_valid(cyc);
      check("bp2_latency", cyc, 32'd22);
      check("bp2_code", {10'd0, codeout}, 32'h000008);
      check("bp2_err", {31'd0, out_err}, 32'd0);
      handshake();

      // Reset at RUN step 10 discards the word.
      send(32'd12345);
      repeat (10) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      check("mid_rst_code", {10'd0, codeout}, 32'd0);
      seen = 1'b0;
      repeat (30) begin
         step();
         if (out_valid) seen = 1'b1;
      end
      check("mid_rst_no_valid", {31'd0, seen}, 32'd0);
      run_word("after_rst", 32'd13, 22'h000010, 1'b0);

      // Round trip against a weighted-sum decoder.
      for (int i = 0; i < 1000; i++) begin
         d = $urandom_range(0, 900139);
         send(d);
         wait_valid(cyc);
         check("rt_latency", cyc, 32'd22);
         check("rt_decode", decode(codeout), d);
         check("rt_err", {31'd0, out_err}, 32'd0);
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
